// File: rtl/rover_pkg.sv
// -----------------------------------------------------------------------------
// rover_pkg
// Shared types and constants for the rover request dispatcher.
//   LOC_W        : width of a room / location number
//   loc_t        : room / location number
//   disp_state_t : dispatcher FSM state (IDLE, MOVE, DWELL)
//   room_valid() : true when a room number lies inside 0..num_locs-1
// -----------------------------------------------------------------------------
package rover_pkg;

  localparam int LOC_W = 4;

  typedef logic [LOC_W-1:0] loc_t;

  // Raw encodings are kept as plain constants so older code that compares
  // against the numeric state values keeps working.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    MOVE  = S_MOVE,
    DWELL = S_DWELL
  } disp_state_t;

  // One extra bit on the compare so that num_locs = 16 still accepts room 15.
  function automatic logic room_valid(input loc_t room, input int num_locs);
    return ({1'b0, room} < (LOC_W+1)'(num_locs));
  endfunction

endpackage

// File: rtl/rover_req_fifo.sv
// -----------------------------------------------------------------------------
// rover_req_fifo
// Synchronous first-in first-out queue of destination rooms.
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-low; empties the queue
//   push   in   write din at this edge (ignored while full)
//   din    in   room to enqueue
//   pop    in   drop the head entry at this edge (ignored while empty)
//   full   out  no free entry
//   empty  out  no stored entry
//   head   out  oldest stored room (meaningless while empty)
// Pointers carry one bit beyond the index so full and empty can be told
// apart when the index bits match.
// -----------------------------------------------------------------------------
module rover_req_fifo
  import rover_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  loc_t din,
  input  logic pop,
  output logic full,
  output logic empty,
  output loc_t head
);

  localparam int AW = $clog2(DEPTH);

  loc_t        mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        push_ok_s;
  logic        pop_ok_s;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    empty     = (wr_ptr_r == rd_ptr_r);
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    head      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Read and write pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/rover_dispatch.sv
// -----------------------------------------------------------------------------
// rover_dispatch
// Queues destination-room requests for the hospital rover, drives the rover
// forward until its reported location matches the head destination, parks it
// for DWELL_CYCLES cycles, then serves the next request. A watchdog raises a
// sticky fault when the rover stays in MOVE for MOVE_TIMEOUT cycles.
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-low
//   req_valid     in   request present
//   req_room      in   requested room
//   req_ready     out  request queue not full
//   current_loc   in   rover location feedback
//   move_switch   out  rover advance enable (combinational)
//   busy          out  dispatcher active or requests pending
//   arrived       out  one-cycle pulse after the rover reaches its target
//   arrived_room  out  room of the most recent arrival
//   req_err       out  one-cycle pulse after an out-of-range room is dropped
//   fault         out  sticky watchdog fault
// -----------------------------------------------------------------------------
module rover_dispatch
  import rover_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int NUM_LOCS     = 10,
  parameter int DWELL_CYCLES = 8,
  parameter int MOVE_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [LOC_W-1:0] req_room,
  output logic             req_ready,
  input  logic [LOC_W-1:0] current_loc,
  output logic             move_switch,
  output logic             busy,
  output logic             arrived,
  output logic [LOC_W-1:0] arrived_room,
  output logic             req_err,
  output logic             fault
);

  localparam int MT_W = $clog2(MOVE_TIMEOUT);
  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [MT_W-1:0] MOVE_LAST  = MT_W'(MOVE_TIMEOUT - 1);
  localparam logic [MT_W-1:0] MOVE_ONE   = MT_W'(1'b1);
  localparam logic [MT_W-1:0] MOVE_ZERO  = MT_W'(1'b0);
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
  localparam logic [DW_W-1:0] DWELL_ONE  = DW_W'(1'b1);
  localparam logic [DW_W-1:0] DWELL_ZERO = DW_W'(1'b0);

  disp_state_t     state_r;
  loc_t            target_r;
  logic [MT_W-1:0] move_timer_r;
  logic [DW_W-1:0] dwell_cnt_r;
  logic            arrived_r;
  loc_t            arrived_room_r;
  logic            req_err_r;
  logic            fault_r;

  logic            fifo_full_s;
  logic            fifo_empty_s;
  loc_t            fifo_head_s;
  logic            room_ok_s;
  logic            push_s;
  logic            pop_s;

  // Request acceptance and head pop. A pop never frees a slot for the same
  // cycle's push because push is gated by the registered full flag.
  always_comb begin
    room_ok_s = room_valid(req_room, NUM_LOCS);
    push_s    = req_valid && !fifo_full_s && room_ok_s;
    pop_s     = (state_r == IDLE) && !fifo_empty_s;
  end

  rover_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (req_room),
    .pop   (pop_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  // Rover drive is combinational on the live location so that the rover is
  // stopped in the very cycle it reports the target, without overshooting.
  always_comb begin
    req_ready   = !fifo_full_s;
    busy        = (state_r != IDLE) || !fifo_empty_s;
    move_switch = (state_r == MOVE) && (current_loc != target_r);
  end

  // Dispatcher FSM, move watchdog, dwell counter and pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= IDLE;
      target_r       <= '0;
      move_timer_r   <= MOVE_ZERO;
      dwell_cnt_r    <= DWELL_ZERO;
      arrived_r      <= 1'b0;
      arrived_room_r <= '0;
      req_err_r      <= 1'b0;
      fault_r        <= 1'b0;
    end else begin
      arrived_r <= 1'b0;
      req_err_r <= req_valid && !fifo_full_s && !room_ok_s;
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            target_r <= fifo_head_s;
            if (fifo_head_s == current_loc) begin
              // Already there: skip MOVE entirely.
              state_r        <= DWELL;
              arrived_r      <= 1'b1;
              arrived_room_r <= fifo_head_s;
              dwell_cnt_r    <= DWELL_LOAD;
            end else begin
              state_r      <= MOVE;
              move_timer_r <= MOVE_ZERO;
            end
          end
        end
        MOVE: begin
          if (current_loc == target_r) begin
            state_r        <= DWELL;
            arrived_r      <= 1'b1;
            arrived_room_r <= target_r;
            dwell_cnt_r    <= DWELL_LOAD;
          end else if (move_timer_r == MOVE_LAST) begin
            // Rover never got there: abandon this target, keep dispatching.
            fault_r  <= 1'b1;
            state_r  <= IDLE;
            target_r <= '0;
          end else begin
            move_timer_r <= move_timer_r + MOVE_ONE;
          end
        end
        DWELL: begin
          if (dwell_cnt_r == DWELL_ZERO) begin
            state_r <= IDLE;
          end else begin
            dwell_cnt_r <= dwell_cnt_r - DWELL_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Registered pulse and status outputs.
  always_comb begin
    arrived      = arrived_r;
    arrived_room = arrived_room_r;
    req_err      = req_err_r;
    fault        = fault_r;
  end

endmodule

// File: tb/tb_rover_dispatch.sv
// -----------------------------------------------------------------------------
// tb_rover_dispatch
// Self-checking bench for rover_dispatch. A rover plant advances the location
// (wrapping at NUM_LOCS) whenever move_switch is high and it is not stalled.
// A request-queue model predicts every output; a compare process checks them
// each cycle, and directed scenarios pin timing with hand-computed numbers.
// -----------------------------------------------------------------------------
module tb_rover_dispatch;

  localparam int DEPTH = 4;
  localparam int NL    = 10;
  localparam int DW    = 8;
  localparam int MT    = 32;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_room;
  logic       req_ready;
  logic [3:0] cur_loc;
  logic       move_switch;
  logic       busy;
  logic       arrived;
  logic [3:0] arrived_room;
  logic       req_err;
  logic       fault;

  rover_dispatch #(
    .DEPTH        (DEPTH),
    .NUM_LOCS     (NL),
    .DWELL_CYCLES (DW),
    .MOVE_TIMEOUT (MT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_room     (req_room),
    .req_ready    (req_ready),
    .current_loc  (cur_loc),
    .move_switch  (move_switch),
    .busy         (busy),
    .arrived      (arrived),
    .arrived_room (arrived_room),
    .req_err      (req_err),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit stall  = 1'b0;

  // Model: pending rooms, the room being travelled to, time spent travelling,
  // remaining parked cycles, and the latched/pulsed outputs.
  int m_q[$];
  bit m_moving;
  int m_tgt;
  int m_age;
  int m_park;
  bit m_arr;
  int m_arr_room;
  bit m_err;
  bit m_fault;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void arrive(input int room);
    m_arr      = 1'b1;
    m_arr_room = room;
    m_park     = DW;
    m_moving   = 1'b0;
  endfunction

  // What the dispatcher must do at one clock edge given the inputs before it.
  function automatic void model_edge(input bit rv, input int rr, input bit rn, input int loc);
    bit push_it;
    int h;
    push_it = 1'b0;
    if (!rn) begin
      m_q.delete();
      m_moving = 1'b0; m_tgt = 0; m_age = 0; m_park = 0;
      m_arr = 1'b0; m_arr_room = 0; m_err = 1'b0; m_fault = 1'b0;
    end else begin
      m_arr = 1'b0;
      m_err = 1'b0;
      if (rv && m_q.size() < DEPTH) begin
        if (rr < NL) push_it = 1'b1;
        else m_err = 1'b1;
      end
      if (m_park > 0) begin
        m_park--;
      end else if (m_moving) begin
        if (loc == m_tgt) arrive(m_tgt);
        else if (m_age == MT - 1) begin
          m_fault  = 1'b1;
          m_moving = 1'b0;
        end else m_age++;
      end else if (m_q.size() > 0) begin
        h = m_q.pop_front();
        if (h == loc) arrive(h);
        else begin
          m_moving = 1'b1;
          m_tgt    = h;
          m_age    = 0;
        end
      end
      if (push_it) m_q.push_back(rr);
    end
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready",    32'(req_ready),    32'(m_q.size() < DEPTH));
      chk("busy",         32'(busy),         32'(m_moving || m_park > 0 || m_q.size() > 0));
      chk("move_switch",  32'(move_switch),  32'(m_moving && (int'(cur_loc) != m_tgt)));
      chk("arrived",      32'(arrived),      32'(m_arr));
      chk("arrived_room", 32'(arrived_room), 32'(m_arr_room));
      chk("req_err",      32'(req_err),      32'(m_err));
      chk("fault",        32'(fault),        32'(m_fault));
    end
  end

  // One clock cycle: apply inputs, step model and rover around the edge,
  // return just after the falling edge with outputs settled.
  task automatic step(input bit rv, input logic [3:0] rr, input bit rn);
    bit ms_pre;
    req_valid = rv;
    req_room  = rr;
    reset     = rn;
    #2;
    ms_pre = move_switch;
    model_edge(rv, int'(rr), rn, int'(cur_loc));
    @(posedge clk);
    #1;
    if (ms_pre && !stall) cur_loc = 4'((int'(cur_loc) + 1) % NL);
    @(negedge clk);
    #1;
  endtask

  int ms_cnt, arr_idx, idle_idx, f_idx, arr_rm;
  int arr_q[$];
  int exp_order[5];

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_room = 4'd0; cur_loc = 4'd0;
    exp_order[0] = 6; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 4;
    @(negedge clk);
    #1;
    cmp_en = 1'b1;

    // Reset state
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_move", 32'(move_switch), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_room", 32'(arrived_room), 32'd0);
    step(1'b0, 4'd0, 1'b1);

    // Single request, rover at 0, room 3
    cur_loc = 4'd0;
    step(1'b1, 4'd3, 1'b1);
    ms_cnt = 32'(move_switch); arr_idx = -1; idle_idx = -1; arr_rm = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 4'd0, 1'b1);
      ms_cnt += 32'(move_switch);
      if (arrived && arr_idx < 0) begin arr_idx = k; arr_rm = int'(arrived_room); end
      if (!busy && idle_idx < 0) idle_idx = k;
    end
    chk("t1_move_cycles", 32'(ms_cnt), 32'd3);
    chk("t1_arrive_cycle", 32'(arr_idx), 32'd5);
    chk("t1_arrive_room", 32'(arr_rm), 32'd3);
    chk("t1_idle_cycle", 32'(idle_idx), 32'd13);

    // Same-room request
    cur_loc = 4'd5;
    step(1'b1, 4'd5, 1'b1);
    ms_cnt = 32'(move_switch); arr_idx = -1; arr_rm = -1;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 4'd0, 1'b1);
      ms_cnt += 32'(move_switch);
      if (arrived && arr_idx < 0) begin arr_idx = k; arr_rm = int'(arrived_room); end
    end
    chk("t2_move_cycles", 32'(ms_cnt), 32'd0);
    chk("t2_arrive_cycle", 32'(arr_idx), 32'd1);
    chk("t2_arrive_room", 32'(arr_rm), 32'd5);

    // Queue fills while the rover is stalled; order preserved
    cur_loc = 4'd0; stall = 1'b1;
    step(1'b1, 4'd6, 1'b1);
    step(1'b1, 4'd1, 1'b1);
    step(1'b1, 4'd2, 1'b1);
    step(1'b1, 4'd3, 1'b1);
    step(1'b1, 4'd4, 1'b1);
    chk("t3_full_ready", 32'(req_ready), 32'd0);
    step(1'b1, 4'd7, 1'b1);
    chk("t3_still_full", 32'(req_ready), 32'd0);
    stall = 1'b0;
    arr_q.delete();
    for (int k = 0; k < 150; k++) begin
      step(1'b0, 4'd0, 1'b1);
      if (arrived) arr_q.push_back(int'(arrived_room));
    end
    chk("t3_arrivals", 32'(arr_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_order", 32'((i < arr_q.size()) ? arr_q[i] : -1), 32'(exp_order[i]));
    end

    // Out-of-range room
    step(1'b1, 4'd12, 1'b1);
    chk("t4_err", 32'(req_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    step(1'b0, 4'd0, 1'b1);
    chk("t4_err_gone", 32'(req_err), 32'd0);
    chk("t4_no_move", 32'(move_switch), 32'd0);

    // Watchdog: rover stuck at 2, target 4
    stall = 1'b1; cur_loc = 4'd2;
    step(1'b1, 4'd4, 1'b1);
    f_idx = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 4'd0, 1'b1);
      if (fault && f_idx < 0) f_idx = k;
    end
    chk("t5_fault_cycle", 32'(f_idx), 32'd33);
    chk("t5_move_off", 32'(move_switch), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    stall = 1'b0;
    step(1'b1, 4'd7, 1'b1);
    arr_rm = -1;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 4'd0, 1'b1);
      if (arrived) arr_rm = int'(arrived_room);
    end
    chk("t5_served_after", 32'(arr_rm), 32'd7);
    chk("t5_fault_sticky", 32'(fault), 32'd1);

    // Reset in the middle of a move
    cur_loc = 4'd0;
    step(1'b1, 4'd5, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk("t6_moving", 32'(move_switch), 32'd1);
    step(1'b0, 4'd0, 1'b0);
    chk("t6_move_off", 32'(move_switch), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_fault", 32'(fault), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_room", 32'(arrived_room), 32'd0);

    // Randomized traffic with stalls, relocations and rare resets
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) cur_loc = 4'($urandom_range(0, NL - 1));
      step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 399) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
